inv_round_key_generator: RTL and testbench
==========================================

INV_ROUND_KEY_GENERATOR -- requirements
Module: inv_round_key_generator

Interface
REQ-001 Parameter ROUNDS, default 10, number of AES-128 rounds; 10 is the only legal value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load_valid  input  1  load_key is valid this cycle.
REQ-005 load_ready  output  1  block can accept a new key.
REQ-006 load_key  input  128  round-10 key (bits [127:120] = key byte 0, word w0 = [127:96]).
REQ-007 key_valid  output  1  round_key/round_idx hold a valid key.
REQ-008 key_ready  input  1  consumer accepts the current key.
REQ-009 round_key  output  128  current round key, same byte order as load_key.
REQ-010 round_idx  output  4  round number of round_key, 10 down to 0.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, EMIT (plus FWD when the configuration macro is defined); load_ready = 1 only in IDLE.
REQ-013 IDLE: on load_valid && load_ready, register load_key; next cycle state = EMIT, key_valid = 1, round_key = load_key, round_idx = 10.
REQ-014 EMIT: on key_valid && key_ready with round_idx = i > 0, next cycle round_key = inverse step of current key, round_idx = i-1; no bubble cycles between consecutive keys.
REQ-015 Inverse step, current words w0..w3: p3 = w3^w2, p2 = w2^w1, p1 = w1^w0, p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[i],24'h0}.
REQ-016 RotWord = left rotate one byte; SubWord = forward AES S-box on each of 4 bytes, implemented inside the block, combinational.
REQ-017 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-018 key_valid high without key_ready: round_key and round_idx held unchanged (stall of any length).
REQ-019 Handshake on round_idx = 0: next cycle key_valid = 0, state = IDLE, load_ready = 1.
REQ-020 load_valid while busy: ignored, not buffered.
REQ-021 key_valid never drops before its handshake completes.
REQ-022 Output registers only; no combinational path from load_key or key_ready to round_key.

Reset
REQ-023 rst asserted: immediately state = IDLE, key_valid = 0, round_idx = 0, round_key = 0, busy = 0, load_ready = 1; any sequence in progress is discarded.
REQ-024 After rst deasserts, first load handshake possible on the first clk edge.

Configuration
REQ-025 Macro AES_INV_KEY_FROM_CIPHER_KEY_EN.
REQ-026 Defined: load_key is the cipher key (round 0); accepted load enters FWD for exactly 10 cycles applying forward expansion with Rcon[1..10], then enters EMIT presenting round 10 as in REQ-013; busy = 1, key_valid = 0 during FWD.
REQ-027 Undefined: no FWD state or forward-expansion logic; load_key is the round-10 key per REQ-013.

Verification
REQ-028 Load d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready = 1 -> 11 consecutive keys, first d014f9a8c9ee2589e13f0cc8b6630ca6 idx 10, second ac7766f319fadc2128d12941575c006e idx 9, last 2b7e151628aed2a6abf7158809cf4f3c idx 0, then load_ready = 1.
REQ-029 Same load, key_ready low 5 cycles at idx 7 -> round_key/idx stable for 5 cycles, sequence resumes with correct idx 6 key.
REQ-030 rst pulse mid-sequence at idx 4 -> key_valid = 0 and load_ready = 1 immediately; new load restarts at idx 10 with new key.
REQ-031 load_valid pulsed at idx 5 with different key -> ignored; sequence completes unchanged.
REQ-032 Macro defined, load 2b7e151628aed2a6abf7158809cf4f3c -> busy = 1, key_valid = 0 for 10 cycles, then idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, continues to idx 0 = original key.
REQ-033 Back-to-back loads, random key_ready -> every emitted key equals reference forward expansion in reverse order.

Source files
------------

// File: rtl/inv_round_key_generator.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0 from a loaded key (AES_INV_KEY_FROM_CIPHER_KEY_EN: load cipher key, expand forward first).
// Round 10 appears one cycle after load (eleven with forward expansion); key_ready low holds the current key indefinitely.
module inv_round_key_generator #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [127:0] load_key,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
  localparam logic [1:0] FWD  = 2'd2;
`endif
  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX[idx*8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = sbox(w[k*8 +: 8]);
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   state;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  sub_in, sub_out;
  logic [3:0]   rcon_idx;
  logic [127:0] inv_key;

  assign {w0, w1, w2, w3} = round_key;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
  // One S-box word is shared: FWD feeds w3 with Rcon[idx+1], EMIT feeds p3 with Rcon[idx].
  logic [31:0]  f0, f1, f2, f3;
  assign sub_in   = (state == FWD) ? w3 : p3;
  assign rcon_idx = (state == FWD) ? round_idx + 4'd1 : round_idx;
  assign f0 = w0 ^ sub_out;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
`else
  assign sub_in   = p3;
  assign rcon_idx = round_idx;
`endif

  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]}) ^ {rcon(rcon_idx), 24'h0};
  assign p0      = w0 ^ sub_out;
  assign inv_key = {p0, p1, p2, p3};

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      round_idx <= '0;
      round_key <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            round_key <= load_key;
`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
            state     <= FWD;
            round_idx <= '0;
`else
            state     <= EMIT;
            round_idx <= LAST_IDX;
            key_valid <= 1'b1;
`endif
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (round_idx == 4'd0) begin
              state     <= IDLE;
              key_valid <= 1'b0;
            end else begin
              round_key <= inv_key;
              round_idx <= round_idx - 4'd1;
            end
          end
        end
`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
        FWD: begin
          // round_idx counts completed forward rounds; the last one lands on round 10.
          round_key <= {f0, f1, f2, f3};
          round_idx <= round_idx + 4'd1;
          if (round_idx == LAST_IDX - 4'd1) begin
            state     <= EMIT;
            key_valid <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_round_key_generator.sv
// Scoreboard bench for inv_round_key_generator: reference key schedule built from GF(2^8) arithmetic, expected keys queued per load.
module tb_inv_round_key_generator;

`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] load_key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;

  inv_round_key_generator #(.ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_key   (load_key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [131:0] expq[$];
  logic [7:0]   sbm[256];
  logic [127:0] rk[11];
  bit           rdy_random = 0;
  bit           after_last = 0;

  task automatic check(input string name, input bit ok, input logic [131:0] act, input logic [131:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_random) key_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_load(input logic [127:0] ck);
    int n;
    int lat;
    expand(ck);
    n = 0;
    while (!load_ready && n < 100) begin tick(); n++; end
    check("load_ready_wait", load_ready, 132'(load_ready), 132'(1));
    for (int r = 10; r >= 0; r--) expq.push_back({4'(r), rk[r]});
    load_valid = 1'b1;
`ifdef AES_INV_KEY_FROM_CIPHER_KEY_EN
    load_key = ck;
`else
    load_key = rk[10];
`endif
    tick();
    load_valid = 1'b0;
    load_key   = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!key_valid && lat < 20) begin
      check("fwd_busy", busy && !key_valid, 132'({busy, key_valid}), 132'(2'b10));
      tick();
      lat++;
    end
    check("load_latency", lat == LAT, 132'(lat), 132'(LAT));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(expq.size() == 0 && load_ready) && n < 400) begin tick(); n++; end
    check("sequence_done", expq.size() == 0 && load_ready, 132'(expq.size()), 132'(0));
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n;
    n = 0;
    while (!(key_valid && round_idx == idx) && n < 100) begin tick(); n++; end
    check("reach_idx", key_valid && round_idx == idx, 132'(round_idx), 132'(idx));
  endtask

  // Monitor: every presented key is compared with the queue head; a handshake retires it.
  initial begin
    logic [131:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (after_last) begin
          check("end_of_sequence", !key_valid && load_ready, 132'({key_valid, load_ready}), 132'(2'b01));
          after_last = 0;
        end else if (key_valid) begin
          if (expq.size() == 0) begin
            check("unexpected_key", 1'b0, {round_idx, round_key}, 132'(0));
          end else begin
            e = expq[0];
            check("round_key", {round_idx, round_key} == e, {round_idx, round_key}, e);
            if (key_ready) begin
              void'(expq.pop_front());
              if (e[131:128] == 4'd0) after_last = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kat;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_key   = '0;
    key_ready  = 1'b0;
    build_sbox();
    kat = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(kat);
    check("model_round10", rk[10] == 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, {4'd10, rk[10]}, {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    check("model_round9", rk[9] == 128'hac7766f319fadc2128d12941575c006e, {4'd9, rk[9]}, {4'd9, 128'hac7766f319fadc2128d12941575c006e});

    #12;
    check("reset_state", !key_valid && load_ready && !busy && round_idx == 4'd0 && round_key == '0,
          {round_idx, round_key}, 132'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    key_ready = 1'b1;

    // Known-answer sequence with a load on the first edge after reset.
    do_load(kat);
    wait_done();

    // Five-cycle stall at round 7.
    do_load(kat);
    wait_idx(4'd7);
    key_ready = 1'b0;
    repeat (5) tick();
    key_ready = 1'b1;
    wait_done();

    // A competing load at round 5 must be dropped.
    do_load(kat);
    wait_idx(4'd5);
    load_valid = 1'b1;
    load_key   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    load_valid = 1'b0;
    wait_done();

    // Asynchronous reset at round 4, then a fresh key.
    do_load(kat);
    wait_idx(4'd4);
    rst = 1'b1;
    #1;
    check("reset_mid_seq", !key_valid && load_ready && !busy && round_idx == 4'd0,
          132'({key_valid, load_ready, busy, round_idx}), 132'(7'b0100000));
    expq.delete();
    tick();
    rst = 1'b0;
    do_load({$urandom, $urandom, $urandom, $urandom});
    wait_done();

    // Back-to-back random keys with random backpressure.
    rdy_random = 1;
    for (int i = 0; i < 30; i++) begin
      do_load({$urandom, $urandom, $urandom, $urandom});
      wait_done();
    end
    rdy_random = 0;
    key_ready  = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
